// File: rtl/mem_lower_pkg.sv
// Shared definitions for the masked 1R1W memory.
// Holds the clear/ready FSM state type, helpers that derive the address width
// and mask lane count from the parameters, and the lane-merge function used by
// both the storage write path and the read bypass path.
package mem_lower_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Widest word the merge helper handles; wider configurations are rejected at elaboration.
  localparam int unsigned MAX_WIDTH = 1024;

  // Address bits needed to index depth words (at least one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? 32'($clog2(depth)) : 32'd1;
  endfunction

  // Number of independently maskable lanes in a word.
  function automatic int unsigned lane_count(input int unsigned width, input int unsigned gran);
    return (gran == 0) ? 32'd1 : width / gran;
  endfunction

  // Take new_word bits in lanes whose mask bit is set, old_word bits elsewhere.
  function automatic logic [MAX_WIDTH-1:0] lane_merge(
    input logic [MAX_WIDTH-1:0] old_word,
    input logic [MAX_WIDTH-1:0] new_word,
    input logic [MAX_WIDTH-1:0] mask,
    input int unsigned          gran
  );
    logic [MAX_WIDTH-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
      if (mask[b / gran]) res[b] = new_word[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_1r1w_masked_core.sv
// Masked 1R1W storage array: one clock, one-cycle registered read.
// Ports: clk, rst_n (async, active-low, clears the read register only),
//   we/waddr/wdata/wmask  masked write (out-of-range addresses are dropped),
//   re/raddr              read request (out-of-range returns zero),
//   rdata                 read data, updated only on re, held otherwise.
// Write and read to the same address in one cycle return the old word.
module mem_1r1w_masked_core
  import mem_lower_pkg::*;
#(
  parameter int unsigned DEPTH     = 48,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned MASK_GRAN = 8,
  localparam int unsigned AW       = addr_width(DEPTH),
  localparam int unsigned LANES    = lane_count(WIDTH, MASK_GRAN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [LANES-1:0] wmask,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Masked write; contents are initialised by the owner's clear sequence.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= WIDTH'(lane_merge(MAX_WIDTH'(mem[waddr]), MAX_WIDTH'(wdata),
                                      MAX_WIDTH'(wmask), MASK_GRAN));
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (32'(raddr) < DEPTH) ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/mem_1r1w_masked_pipe.sv
// Masked 1R1W memory with power-on clear and configurable read latency.
// Ports: clk, rst_n (async active-low); R0_addr/R0_en read request,
//   R0_data/R0_valid read result READ_LATENCY cycles later (data held between
//   valids); W0_addr/W0_en/W0_data/W0_mask masked write; init_busy high while
//   the array is being cleared after reset (exactly DEPTH cycles).
// Build option: MEM_BYPASS_EN forwards a same-cycle same-address write into the
//   read result (merged per mask); without it such a read sees the old word.
module mem_1r1w_masked_pipe
  import mem_lower_pkg::*;
#(
  parameter int unsigned DEPTH        = 48,
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned MASK_GRAN    = 8,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned AW          = addr_width(DEPTH),
  localparam int unsigned LANES       = lane_count(WIDTH, MASK_GRAN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    R0_addr,
  input  logic             R0_en,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  input  logic [AW-1:0]    W0_addr,
  input  logic             W0_en,
  input  logic [WIDTH-1:0] W0_data,
  input  logic [LANES-1:0] W0_mask,
  output logic             init_busy
);

  // Parameter legality.
  if ((MASK_GRAN == 0) || ((WIDTH % MASK_GRAN) != 0)) begin : g_bad_gran
    $error("WIDTH must be a non-zero multiple of MASK_GRAN");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 3)) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..3");
  end
  if ((DEPTH < 2) || (DEPTH > 4096)) begin : g_bad_depth
    $error("DEPTH must be in 2..4096");
  end
  if (WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("WIDTH exceeds MAX_WIDTH");
  end

  state_t          state;
  logic [AW-1:0]   clr_cnt;

  // Clear sequencer: walks every address once after reset, then serves traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state     <= READY;
            init_busy <= 1'b0;
            clr_cnt   <= '0;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        READY: begin
          state <= READY;
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  logic             core_we_c;
  logic [AW-1:0]    core_waddr_c;
  logic [WIDTH-1:0] core_wdata_c;
  logic [LANES-1:0] core_wmask_c;
  logic             rd_go_c;
  logic [WIDTH-1:0] core_rdata;
  logic [WIDTH-1:0] s1_data_c;

  // Write port is owned by the clear sequencer until the array is ready.
  always_comb begin
    core_we_c    = 1'b0;
    core_waddr_c = W0_addr;
    core_wdata_c = W0_data;
    core_wmask_c = W0_mask;
    rd_go_c      = 1'b0;
    if (state == CLEAR) begin
      core_we_c    = 1'b1;
      core_waddr_c = clr_cnt;
      core_wdata_c = '0;
      core_wmask_c = '1;
    end else begin
      core_we_c = W0_en;
      rd_go_c   = R0_en;
    end
  end

  mem_1r1w_masked_core #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .MASK_GRAN (MASK_GRAN)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (core_we_c),
    .waddr (core_waddr_c),
    .wdata (core_wdata_c),
    .wmask (core_wmask_c),
    .re    (rd_go_c),
    .raddr (R0_addr),
    .rdata (core_rdata)
  );

`ifdef MEM_BYPASS_EN
  logic             byp_hit;
  logic [WIDTH-1:0] byp_data;
  logic [LANES-1:0] byp_mask;

  // Capture a colliding write alongside the read so it can be merged onto the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
      byp_mask <= '0;
    end else if (rd_go_c) begin
      byp_hit  <= W0_en && (W0_addr == R0_addr) && (32'(W0_addr) < DEPTH);
      byp_data <= W0_data;
      byp_mask <= W0_mask;
    end
  end

  assign s1_data_c = byp_hit ?
      WIDTH'(lane_merge(MAX_WIDTH'(core_rdata), MAX_WIDTH'(byp_data),
                        MAX_WIDTH'(byp_mask), MASK_GRAN)) : core_rdata;
`else
  assign s1_data_c = core_rdata;
`endif

  logic [READ_LATENCY-1:0] vld;

  // Valid shift chain; bit 0 lines up with the core read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= rd_go_c;
      for (int k = 1; k < int'(READ_LATENCY); k++) vld[k] <= vld[k-1];
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign R0_data  = s1_data_c;
    assign R0_valid = vld[0];
  end else begin : g_latn
    logic [WIDTH-1:0] dly [READ_LATENCY-1];

    // Data stages advance only with their valid, so the output holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < int'(READ_LATENCY) - 1; k++) dly[k] <= '0;
      end else begin
        if (vld[0]) dly[0] <= s1_data_c;
        for (int k = 1; k < int'(READ_LATENCY) - 1; k++) begin
          if (vld[k]) dly[k] <= dly[k-1];
        end
      end
    end

    assign R0_data  = dly[READ_LATENCY-2];
    assign R0_valid = vld[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_mem_1r1w_masked_pipe.sv
// Directed bench for mem_1r1w_masked_pipe: three instances at READ_LATENCY 1,2,3
// share one stimulus stream. Expected values are hand-computed per scenario.
module tb_mem_1r1w_masked_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  R0_addr;
  logic        R0_en;
  logic [5:0]  W0_addr;
  logic        W0_en;
  logic [63:0] W0_data;
  logic [7:0]  W0_mask;

  logic [63:0] rdata  [3];
  logic        rvalid [3];
  logic        busy   [3];

  int          checks = 0;
  int          errors = 0;
  int          obs_cyc [3];
  logic [63:0] obs_dat [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_1r1w_masked_pipe #(
      .DEPTH        (48),
      .WIDTH        (64),
      .MASK_GRAN    (8),
      .READ_LATENCY (g + 1)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .R0_addr   (R0_addr),
      .R0_en     (R0_en),
      .R0_data   (rdata[g]),
      .R0_valid  (rvalid[g]),
      .W0_addr   (W0_addr),
      .W0_en     (W0_en),
      .W0_data   (W0_data),
      .W0_mask   (W0_mask),
      .init_busy (busy[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [5:0] a, input logic [63:0] d, input logic [7:0] m);
    W0_addr = a;
    W0_data = d;
    W0_mask = m;
    W0_en   = 1'b1;
    tick();
    W0_en   = 1'b0;
  endtask

  // Issue one read (plus any write already set up) and record when/what each instance returned.
  task automatic run_read(input logic [5:0] a);
    R0_addr = a;
    R0_en   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      obs_cyc[i] = 0;
      obs_dat[i] = 'x;
    end
    for (int c = 1; c <= 5; c++) begin
      tick();
      R0_en = 1'b0;
      W0_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (rvalid[i] === 1'b1) begin
          obs_cyc[i] = (obs_cyc[i] == 0) ? c : -1;
          obs_dat[i] = rdata[i];
        end
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_busy L=%0d got %b want 1", i + 1, busy[i]);
      end
      checks++;
      if (rvalid[i] !== 1'b0 || rdata[i] !== 64'h0) begin
        errors++;
        $display("FAIL reset_out L=%0d got valid=%b data=%h want 0/0", i + 1, rvalid[i], rdata[i]);
      end
    end
    rst_n = 1'b1;
    n = 0;
    while (busy[0] === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 48) begin
      errors++;
      $display("FAIL clear_cycles got %0d want 48", n);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL clear_done L=%0d got busy=%b want 0", i + 1, busy[i]);
      end
    end
    run_read(6'd47);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cyc[i] !== i + 1 || obs_dat[i] !== 64'h0) begin
        errors++;
        $display("FAIL read47 L=%0d got cyc=%0d data=%h want cyc=%0d data=0", i + 1, obs_cyc[i], obs_dat[i], i + 1);
      end
    end
  endtask

  task automatic test_masked_write();
    write_word(6'd5, 64'h1122334455667788, 8'hFF);
    write_word(6'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    run_read(6'd5);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cyc[i] !== i + 1) begin
        errors++;
        $display("FAIL masked_latency L=%0d got cycle %0d want %0d", i + 1, obs_cyc[i], i + 1);
      end
      checks++;
      if (obs_dat[i] !== 64'h11223344AAAAAAAA) begin
        errors++;
        $display("FAIL masked_data L=%0d got %h want 11223344aaaaaaaa", i + 1, obs_dat[i]);
      end
      checks++;
      if (rdata[i] !== 64'h11223344AAAAAAAA) begin
        errors++;
        $display("FAIL hold_data L=%0d got %h want 11223344aaaaaaaa", i + 1, rdata[i]);
      end
    end
  endtask

  task automatic test_mask_zero();
    write_word(6'd5, 64'hDEADBEEFDEADBEEF, 8'h00);
    run_read(6'd5);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cyc[i] !== i + 1 || obs_dat[i] !== 64'h11223344AAAAAAAA) begin
        errors++;
        $display("FAIL mask_zero L=%0d got cyc=%0d data=%h want data=11223344aaaaaaaa", i + 1, obs_cyc[i], obs_dat[i]);
      end
    end
  endtask

  task automatic test_same_addr();
    logic [63:0] exp;
`ifdef MEM_BYPASS_EN
    exp = 64'h00000000000000FF;
`else
    exp = 64'h0;
`endif
    W0_addr = 6'd9;
    W0_data = 64'hFFFFFFFFFFFFFFFF;
    W0_mask = 8'h01;
    W0_en   = 1'b1;
    run_read(6'd9);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cyc[i] !== i + 1 || obs_dat[i] !== exp) begin
        errors++;
        $display("FAIL same_addr L=%0d got cyc=%0d data=%h want data=%h", i + 1, obs_cyc[i], obs_dat[i], exp);
      end
    end
    run_read(6'd9);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_dat[i] !== 64'h00000000000000FF) begin
        errors++;
        $display("FAIL same_addr_after L=%0d got %h want ff", i + 1, obs_dat[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    W0_addr = 6'd60;
    W0_data = 64'hCAFEF00DCAFEF00D;
    W0_mask = 8'hFF;
    W0_en   = 1'b1;
    run_read(6'd50);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cyc[i] !== i + 1 || obs_dat[i] !== 64'h0) begin
        errors++;
        $display("FAIL oor_read L=%0d got cyc=%0d data=%h want cyc=%0d data=0", i + 1, obs_cyc[i], obs_dat[i], i + 1);
      end
    end
    run_read(6'd9);
    run_read(6'd12);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cyc[i] !== i + 1 || obs_dat[i] !== 64'h0) begin
        errors++;
        $display("FAIL oor_alias L=%0d got cyc=%0d data=%h want data=0", i + 1, obs_cyc[i], obs_dat[i]);
      end
    end
  endtask

  task automatic test_independent();
    W0_addr = 6'd20;
    W0_data = 64'h5555666677778888;
    W0_mask = 8'hFF;
    W0_en   = 1'b1;
    run_read(6'd5);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_dat[i] !== 64'h11223344AAAAAAAA) begin
        errors++;
        $display("FAIL indep_read L=%0d got %h want 11223344aaaaaaaa", i + 1, obs_dat[i]);
      end
    end
    run_read(6'd20);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_dat[i] !== 64'h5555666677778888) begin
        errors++;
        $display("FAIL indep_write L=%0d got %h want 5555666677778888", i + 1, obs_dat[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] val [4];
    for (int k = 0; k < 4; k++) begin
      val[k] = {4{16'h1000 + 16'(k)}};
      write_word(6'(k), val[k], 8'hFF);
    end
    R0_addr = 6'd0;
    R0_en   = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        logic exp_v;
        exp_v = (c >= i + 1) && (c <= i + 4);
        checks++;
        if (rvalid[i] !== exp_v) begin
          errors++;
          $display("FAIL b2b_valid L=%0d cyc=%0d got %b want %b", i + 1, c, rvalid[i], exp_v);
        end
        if (exp_v) begin
          checks++;
          if (rdata[i] !== val[c - i - 1]) begin
            errors++;
            $display("FAIL b2b_data L=%0d cyc=%0d got %h want %h", i + 1, c, rdata[i], val[c - i - 1]);
          end
        end
      end
      if (c < 4) R0_addr = 6'(c);
      else R0_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    int seen;
    R0_addr = 6'd0;
    R0_en   = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (rvalid[1] !== (c >= 2)) begin
        errors++;
        $display("FAIL midrst_valid cyc=%0d got %b want %b", c, rvalid[1], (c >= 2));
      end
      R0_addr = 6'(c);
    end
    // Second valid of the latency-2 instance is showing now.
    rst_n = 1'b0;
    R0_en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rvalid[i] !== 1'b0 || rdata[i] !== 64'h0 || busy[i] !== 1'b1) begin
        errors++;
        $display("FAIL midrst_async L=%0d got valid=%b data=%h busy=%b want 0/0/1", i + 1, rvalid[i], rdata[i], busy[i]);
      end
    end
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    seen = 0;
    while (busy[1] === 1'b1 && n < 100) begin
      tick();
      n++;
      for (int i = 0; i < 3; i++) if (rvalid[i] !== 1'b0) seen++;
    end
    checks++;
    if (n != 48 || seen != 0) begin
      errors++;
      $display("FAIL midrst_clear got cycles=%0d valids=%0d want 48/0", n, seen);
    end
    run_read(6'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cyc[i] !== i + 1 || obs_dat[i] !== 64'h0) begin
        errors++;
        $display("FAIL midrst_cleared L=%0d got cyc=%0d data=%h want data=0", i + 1, obs_cyc[i], obs_dat[i]);
      end
    end
  endtask

  task automatic test_clear_ignore();
    int n;
    write_word(6'd3, 64'h0123456789ABCDEF, 8'hFF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    while (busy[0] === 1'b1 && n < 100) begin
      R0_addr = 6'd3;
      R0_en   = 1'b1;
      W0_addr = 6'd7;
      W0_data = 64'hFFFFFFFFFFFFFFFF;
      W0_mask = 8'hFF;
      W0_en   = 1'b1;
      tick();
      n++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rvalid[i] !== 1'b0) begin
          errors++;
          $display("FAIL clear_no_valid L=%0d cyc=%0d got %b want 0", i + 1, n, rvalid[i]);
        end
      end
    end
    R0_en = 1'b0;
    W0_en = 1'b0;
    checks++;
    if (n != 48) begin
      errors++;
      $display("FAIL clear_ignore_cycles got %0d want 48", n);
    end
    run_read(6'd3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_cyc[i] !== i + 1 || obs_dat[i] !== 64'h0) begin
        errors++;
        $display("FAIL clear_addr3 L=%0d got cyc=%0d data=%h want data=0", i + 1, obs_cyc[i], obs_dat[i]);
      end
    end
    run_read(6'd7);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_dat[i] !== 64'h0) begin
        errors++;
        $display("FAIL clear_addr7 L=%0d got %h want 0", i + 1, obs_dat[i]);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    R0_addr = '0;
    R0_en   = 1'b0;
    W0_addr = '0;
    W0_en   = 1'b0;
    W0_data = '0;
    W0_mask = '0;
    test_reset();
    test_masked_write();
    test_mask_zero();
    test_same_addr();
    test_out_of_range();
    test_independent();
    test_back_to_back();
    test_reset_mid_read();
    test_clear_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
